threshold_error: RTL and testbench

- Training-loop partner of the associate neuron: consumes the neuron's forward result `res` and a target stream.
- Applies a step activation and returns the signed error `err = tgt - act` to the neuron's backward input.
- Keeps per-epoch mismatch statistics and flags convergence, so benches and a future trainer sequencer no longer compute activation and error by hand.

---
 rtl/threshold_error_if.sv | 27 ++
 rtl/threshold_error.sv | 120 ++++++++++++
 tb/tb_threshold_error.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/threshold_error_if.sv
// Handshake bundle for threshold_error: the result and target streams coming
// in from the neuron and trainer, and the error stream going back to the
// neuron's backward port.
interface threshold_error_if #(
  parameter int RESW = 16,
  parameter int ERRW = 16
);
  logic            res_valid;
  logic [RESW-1:0] res_data;
  logic            res_ready;
  logic            tgt_valid;
  logic [RESW-1:0] tgt_data;
  logic            tgt_ready;
  logic            err_valid;
  logic [ERRW-1:0] err_data;
  logic            err_ready;

  modport master (
    output res_valid, res_data, tgt_valid, tgt_data, err_ready,
    input  res_ready, tgt_ready, err_valid, err_data
  );

  modport slave (
    input  res_valid, res_data, tgt_valid, tgt_data, err_ready,
    output res_ready, tgt_ready, err_valid, err_data
  );
endinterface

// File: rtl/threshold_error.sv
// threshold_error: step activation of the neuron result, signed error against
// the target, and per-epoch mismatch statistics with a convergence flag.
// Optional build macro THRESHOLD_ERROR_SATURATE_EN: when defined, the error
// saturates to the signed ERRW range instead of wrapping.
module threshold_error #(
  parameter int              RESW  = 16,
  parameter int              ERRW  = 16,
  parameter logic [RESW-1:0] HIGH  = 16'h00ff,
  parameter logic [RESW-1:0] LOW   = 16'h0000,
  parameter int              EPOCH = 4,
  parameter int              CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  threshold_error_if.slave     bus,
  output logic [RESW-1:0]      act_data,
  output logic                 miss,
  output logic                 epoch_done,
  output logic [CNTW-1:0]      miss_count,
  output logic                 converged
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ERR  = 1'b1;

  localparam int DW = RESW + 1;
  localparam int WW = (ERRW > DW) ? ERRW : DW;
  localparam int SW = (EPOCH > 1) ? $clog2(EPOCH) : 1;
  localparam logic [SW-1:0] LAST = SW'(EPOCH - 1);

  logic [0:0]           state;
  logic [SW-1:0]        sample_cnt;
  logic [CNTW-1:0]      run_cnt;
  logic [ERRW-1:0]      err_q;
  logic                 xfer;
  logic [RESW-1:0]      act_next;
  logic signed [DW-1:0] diff;
  logic signed [WW-1:0] diff_wide;
  logic [ERRW-1:0]      err_next;
  logic                 miss_next;
  logic [CNTW-1:0]      run_next;

  // Both streams are accepted together, and only while idle and out of reset.
  assign xfer          = !rst && (state == IDLE) && bus.res_valid && bus.tgt_valid;
  assign bus.res_ready = xfer;
  assign bus.tgt_ready = xfer;
  assign bus.err_valid = (state == ERR);
  assign bus.err_data  = err_q;

  // Activation, error and running-miss candidates for the sample on the bus.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    act_next  = bus.res_data[RESW-1] ? LOW : HIGH;
    diff      = $signed({bus.tgt_data[RESW-1], bus.tgt_data})
              - $signed({act_next[RESW-1], act_next});
    diff_wide = WW'(diff);
`ifdef THRESHOLD_ERROR_SATURATE_EN
    if (&diff_wide[WW-1:ERRW-1] || ~|diff_wide[WW-1:ERRW-1]) begin
      err_next = ERRW'(diff_wide);
    end else if (diff_wide[WW-1]) begin
      err_next           = '0;
      err_next[ERRW-1]   = 1'b1;
    end else begin
      err_next           = '1;
      err_next[ERRW-1]   = 1'b0;
    end
`else
    err_next  = ERRW'(diff_wide);
`endif
    miss_next = (act_next != bus.tgt_data);
    run_next  = (miss_next && (run_cnt != '1)) ? run_cnt + 1'b1 : run_cnt;
  end

  // Handshake FSM plus the per-sample result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      act_data <= '0;
      err_q    <= '0;
      miss     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE:    if (xfer && en) state <= ERR;
        ERR:     if (bus.err_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (xfer) begin
        act_data <= act_next;
        err_q    <= err_next;
        miss     <= miss_next;
      end
    end
  end

  // Epoch bookkeeping: sample counter, running misses, end-of-epoch summary.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      run_cnt    <= '0;
      epoch_done <= 1'b0;
      miss_count <= '0;
      converged  <= 1'b0;
    end else begin
      epoch_done <= 1'b0;
      if (xfer) begin
        if (sample_cnt == LAST) begin
          sample_cnt <= '0;
          run_cnt    <= '0;
          epoch_done <= 1'b1;
          miss_count <= run_next;
          converged  <= (run_next == '0);
        end else begin
          sample_cnt <= sample_cnt + 1'b1;
          run_cnt    <= run_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_threshold_error.sv
// Self-checking bench for threshold_error: reset state, hand-written handshake
// corner cases, a table of samples spanning three epochs, and an ERRW=8 /
// EPOCH=1 instance for the error reduction and single-sample epochs.
module tb_threshold_error;
  logic clk = 1'b0;
  logic rst;
  logic en;
  logic en8;

  always #5 clk = ~clk;

  threshold_error_if #(.RESW(16), .ERRW(16)) bus ();
  threshold_error_if #(.RESW(16), .ERRW(8))  bus8 ();

  logic [15:0] act_data,  act_data8;
  logic        miss,      miss8;
  logic        epoch_done, epoch_done8;
  logic [7:0]  miss_count, miss_count8;
  logic        converged, converged8;

  threshold_error #(
    .RESW(16), .ERRW(16), .HIGH(16'h00ff), .LOW(16'h0000), .EPOCH(4), .CNTW(8)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus),
    .act_data(act_data), .miss(miss), .epoch_done(epoch_done),
    .miss_count(miss_count), .converged(converged)
  );

  threshold_error #(
    .RESW(16), .ERRW(8), .HIGH(16'h00ff), .LOW(16'h0000), .EPOCH(1), .CNTW(8)
  ) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .bus(bus8),
    .act_data(act_data8), .miss(miss8), .epoch_done(epoch_done8),
    .miss_count(miss_count8), .converged(converged8)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic        en;
    logic [15:0] res;
    logic [15:0] tgt;
    logic [15:0] act;
    logic        miss;
    logic        done;
    logic [7:0]  mc;
    logic        conv;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference error: exact integer difference, reduced to errw bits.
  function automatic logic [15:0] model_err(input logic [15:0] act, input logic [15:0] tgt,
                                            input int errw);
    int d;
`ifdef THRESHOLD_ERROR_SATURATE_EN
    int lo;
    int hi;
`endif
    d = int'($signed(tgt)) - int'($signed(act));
`ifdef THRESHOLD_ERROR_SATURATE_EN
    lo = -(1 << (errw - 1));
    hi = (1 << (errw - 1)) - 1;
    if (d > hi) d = hi;
    if (d < lo) d = lo;
`endif
    return 16'(d) & 16'((1 << errw) - 1);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Present one sample on both streams, wait for the joint transfer, check the
  // registered activation and miss. Valids stay asserted for back-to-back use.
  task automatic send(input logic e, input logic [15:0] r, input logic [15:0] t,
                      input logic [15:0] a_exp, input logic m_exp, output int waits);
    en            = e;
    bus.res_data  = r;
    bus.tgt_data  = t;
    bus.res_valid = 1'b1;
    bus.tgt_valid = 1'b1;
    if (e) sb.push_back(model_err(a_exp, t, 16));
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.res_ready && bus.tgt_ready) break;
      waits++;
      if (waits > 20) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: no transfer after %0d cycles, res=%h", waits, r);
        return;
      end
    end
    @(posedge clk);
    #1;
    check("act_data", act_data, a_exp);
    check("miss", miss, m_exp);
  endtask

  // Scoreboard side: every error handshake pops one expected value.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.err_valid && bus.err_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL err_unexpected: got err_data %h with nothing expected", bus.err_data);
        end else begin
          e = sb.pop_front();
          check("err_data", bus.err_data, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  ok;

    // Epoch 1 (en=0): AND-gate targets, one mismatch.
    vecs[0]  = '{1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[1]  = '{1'b0, 16'hfff0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[2]  = '{1'b0, 16'h0003, 16'h0000, 16'h00ff, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0010, 16'h00ff, 16'h00ff, 1'b0, 1'b1, 8'd1, 1'b0};
    // Epoch 2 (en=0): no mismatches, res = 0 counts as non-negative.
    vecs[4]  = '{1'b0, 16'hffff, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[5]  = '{1'b0, 16'hc000, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[6]  = '{1'b0, 16'h8001, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 16'h00ff, 16'h00ff, 1'b0, 1'b1, 8'd0, 1'b1};
    // Epoch 3 (en=1): every sample misses, including the out-of-range difference.
    vecs[8]  = '{1'b1, 16'h7fff, 16'h0000, 16'h00ff, 1'b1, 1'b0, 8'd0, 1'b1};
    vecs[9]  = '{1'b1, 16'hffff, 16'h00ff, 16'h0000, 1'b1, 1'b0, 8'd0, 1'b1};
    vecs[10] = '{1'b1, 16'h1234, 16'h8000, 16'h00ff, 1'b1, 1'b0, 8'd0, 1'b1};
    vecs[11] = '{1'b1, 16'h8000, 16'h7fff, 16'h0000, 1'b1, 1'b1, 8'd4, 1'b0};

    en             = 1'b0;
    en8            = 1'b0;
    bus.res_data   = '0;
    bus.tgt_data   = '0;
    bus.res_valid  = 1'b1;
    bus.tgt_valid  = 1'b1;
    bus.err_ready  = 1'b0;
    bus8.res_data  = '0;
    bus8.tgt_data  = '0;
    bus8.res_valid = 1'b0;
    bus8.tgt_valid = 1'b0;
    bus8.err_ready = 1'b0;
    rst            = 1'b1;

    // Ready stays low during reset even with both valids high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_ready", bus.res_ready, 1'b0);
    check("rst_tgt_ready", bus.tgt_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    bus.tgt_valid = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    check("reset_res_ready",  bus.res_ready, 1'b0);
    check("reset_tgt_ready",  bus.tgt_ready, 1'b0);
    check("reset_err_valid",  bus.err_valid, 1'b0);
    check("reset_err_data",   bus.err_data, 16'h0000);
    check("reset_act_data",   act_data, 16'h0000);
    check("reset_miss",       miss, 1'b0);
    check("reset_epoch_done", epoch_done, 1'b0);
    check("reset_miss_count", miss_count, 8'd0);
    check("reset_converged",  converged, 1'b0);
    @(posedge clk);
    #1;

    // A: negative result against target 0x00ff, error held for 3 cycles.
    send(1'b1, 16'hfff0, 16'h00ff, 16'h0000, 1'b1, w);
    bus.res_valid = 1'b0;
    bus.tgt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_err_valid", bus.err_valid, 1'b1);
      check("hold_err_data", bus.err_data, 16'h00ff);
    end
    @(posedge clk);
    #1;
    bus.err_ready = 1'b1;

    // B: positive result matches the target, zero error.
    send(1'b1, 16'h0005, 16'h00ff, 16'h00ff, 1'b0, w);

    // C: result without target is never consumed alone.
    en            = 1'b0;
    bus.res_valid = 1'b1;
    bus.tgt_valid = 1'b0;
    bus.res_data  = 16'hfff0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lone_res_ready", bus.res_ready, 1'b0);
      check("lone_tgt_ready", bus.tgt_ready, 1'b0);
    end
    check("lone_no_transfer", act_data, 16'h00ff);
    @(posedge clk);
    #1;
    send(1'b0, 16'hfff0, 16'h0000, 16'h0000, 1'b0, w);
    check("joint_same_cycle", w, 0);

    // D: reset while an error is pending drops it.
    bus.err_ready = 1'b0;
    send(1'b1, 16'h0001, 16'h0000, 16'h00ff, 1'b1, w);
    bus.res_valid = 1'b0;
    bus.tgt_valid = 1'b0;
    @(negedge clk);
    check("pending_err_valid", bus.err_valid, 1'b1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("dropped_err_valid", bus.err_valid, 1'b0);
    check("dropped_act_data", act_data, 16'h0000);
    @(posedge clk);
    #1;
    bus.err_ready = 1'b1;

    // Table: three epochs of back-to-back samples.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].en, vecs[i].res, vecs[i].tgt, vecs[i].act, vecs[i].miss, w);
      check("throughput_waits", w, (i > 0 && vecs[i-1].en) ? 1 : 0);
      check("epoch_done", epoch_done, vecs[i].done);
      check("miss_count", miss_count, vecs[i].mc);
      check("converged", converged, vecs[i].conv);
      if (!vecs[i].en) check("no_err_when_disabled", bus.err_valid, 1'b0);
    end
    bus.res_valid = 1'b0;
    bus.tgt_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    check("epoch_stats_hold", miss_count, 8'd4);

    // ERRW=8, EPOCH=1 instance: error reduction and per-sample epochs.
    en8            = 1'b1;
    bus8.res_data  = 16'h0001;
    bus8.tgt_data  = 16'h8000;
    bus8.res_valid = 1'b1;
    bus8.tgt_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.res_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL dut8_timeout: no transfer on the ERRW=8 instance");
    end
    @(posedge clk);
    #1;
    bus8.res_valid = 1'b0;
    bus8.tgt_valid = 1'b0;
    check("e8_act_data", act_data8, 16'h00ff);
    check("e8_miss", miss8, 1'b1);
    check("e8_err_valid", bus8.err_valid, 1'b1);
    check("e8_err_data", bus8.err_data, 8'(model_err(16'h00ff, 16'h8000, 8)));
    check("e8_epoch_done", epoch_done8, 1'b1);
    check("e8_miss_count", miss_count8, 8'd1);
    check("e8_converged", converged8, 1'b0);
    bus8.err_ready = 1'b1;
    @(posedge clk);
    #1;
    check("e8_err_released", bus8.err_valid, 1'b0);
    check("e8_epoch_pulse_ends", epoch_done8, 1'b0);

    en8            = 1'b0;
    bus8.res_data  = 16'h0005;
    bus8.tgt_data  = 16'h00ff;
    bus8.res_valid = 1'b1;
    bus8.tgt_valid = 1'b1;
    @(negedge clk);
    check("e8_second_ready", bus8.res_ready, 1'b1);
    @(posedge clk);
    #1;
    bus8.res_valid = 1'b0;
    bus8.tgt_valid = 1'b0;
    check("e8_second_miss", miss8, 1'b0);
    check("e8_second_epoch_done", epoch_done8, 1'b1);
    check("e8_second_miss_count", miss_count8, 8'd0);
    check("e8_second_converged", converged8, 1'b1);
    check("e8_second_no_err", bus8.err_valid, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
